lane_rr_scheduler: RTL
======================

LANE_RR_SCHEDULER -- requirements
Module: lane_rr_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4, number of lanes arbitrated (range 2..16).
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 5, maximum grant cycles per lane while others wait (range 1..255).
REQ-003 The block SHALL have parameter CLEAR_CYCLES, default 2, all-red gap length in cycles (range 1..15), used only when ALL_RED_GAP_EN is defined.
REQ-004 The block SHALL derive IDX_W = clog2(NUM_LANES) and CNT_W = clog2(DWELL_CYCLES+1).
REQ-005 Port clk, input, 1: single clock, all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port lane_req, input, NUM_LANES: bit i high means lane i has traffic waiting.
REQ-008 Port grant, output, NUM_LANES: one-hot green lane; all-zero only during the clearance gap.
REQ-009 Port grant_idx, output, IDX_W: binary index of the current or pending lane.
REQ-010 Port dwell_cnt, output, CNT_W: cycles the current lane has held green since its grant or last idle clear.
REQ-011 Port switch_pulse, output, 1: high for exactly one cycle, the cycle after grant_idx changes.
REQ-012 Port all_red, output, 1: high while in the CLEAR state; tied 0 when ALL_RED_GAP_EN is undefined.

Function
REQ-013 All outputs SHALL be registered; decisions use the lane_req sampled on the same edge, so the response latency is 1 cycle.
REQ-014 States SHALL be GREEN and CLEAR (CLEAR exists only with ALL_RED_GAP_EN).
REQ-015 The next lane SHALL be the first i with lane_req[i]=1, searched cur+1, cur+2, ..., cur+NUM_LANES-1 modulo NUM_LANES. The current lane is never a candidate.
REQ-016 In GREEN with a timeout (dwell_cnt == DWELL_CYCLES-1) and a candidate found, the block SHALL switch to the candidate.
REQ-017 In GREEN with a timeout and no candidate, the block SHALL keep grant and set dwell_cnt to 0.
REQ-018 In GREEN before timeout, with lane_req[cur]=1, the block SHALL keep grant and increment dwell_cnt by 1.
REQ-019 In GREEN before timeout, with lane_req[cur]=0 and a candidate found, the block SHALL switch early.
REQ-020 In GREEN before timeout, with lane_req[cur]=0 and no candidate, the block SHALL keep grant and set dwell_cnt to 0.
REQ-021 On a switch, the block SHALL set grant_idx to the candidate, set dwell_cnt to 0, and assert switch_pulse in the following cycle.
REQ-022 dwell_cnt SHALL never exceed DWELL_CYCLES-1 and SHALL never wrap.
REQ-023 With DWELL_CYCLES=1, every GREEN cycle SHALL be a timeout.
REQ-024 lane_req bits changing mid-dwell SHALL only affect the decision on the edge that samples them. There is no latching.

Reset
REQ-025 A reset cycle SHALL force state GREEN, grant_idx=0, grant=1 (lane 0), dwell_cnt=0, switch_pulse=0, all_red=0, and the clear-gap counter to 0.
REQ-026 Reset SHALL take priority over every transition, including mid-CLEAR and the switch edge itself.

Configuration
REQ-027 The macro ALL_RED_GAP_EN SHALL control the clearance gap.
REQ-028 With ALL_RED_GAP_EN defined, a switch SHALL behave as follows:
- enter CLEAR with grant=0 and all_red=1 for CLEAR_CYCLES cycles;
- grant_idx SHALL already show the new lane during the gap;
- then return to GREEN with grant set to the new lane and dwell_cnt=0;
- switch_pulse SHALL be asserted on the first CLEAR cycle;
- lane_req SHALL be ignored during CLEAR.
REQ-029 Without ALL_RED_GAP_EN, a switch SHALL be direct GREEN-to-GREEN, the CLEAR state and its counter SHALL be absent, and all_red SHALL be 0.

Verification
REQ-030 A bench SHALL cover each of the following directed scenarios, using defaults and ALL_RED_GAP_EN undefined unless stated otherwise.
- Round-robin: reset, then lane_req=4'b1111 held -> grant_idx runs 0,1,2,3,0, with each lane green 5 cycles and switch_pulse every 5th cycle.
- Early switch: lane_req=4'b0100 after reset -> grant_idx=2 one cycle later, dwell_cnt=0.
- Idle hold: lane_req=4'b0000 -> grant stays 4'b0001 and dwell_cnt stays 0 indefinitely.
- Timeout with no candidate: lane 1 granted, lane_req=4'b0010 for 12 cycles -> grant_idx stays 1 and dwell_cnt runs 0,1,2,3,4,0,1,...
- Wrap search: lane 3 granted, lane_req=4'b1011 held to timeout -> next grant_idx=0, not 1.
- ALL_RED_GAP_EN defined, CLEAR_CYCLES=2, lane_req=4'b0011: the switch 0->1 gives grant=0 and all_red=1 for 2 cycles, then grant=4'b0010; reset asserted mid-CLEAR gives grant=4'b0001 on the next cycle.

Source files
------------

// File: rtl/lane_rr_scheduler.sv
// Round-robin lane scheduler with per-lane dwell limit and registered grant outputs.
// Optional all-red clearance gap between grants when ALL_RED_GAP_EN is defined.
module lane_rr_scheduler #(
    parameter int NUM_LANES    = 4,
    parameter int DWELL_CYCLES = 5,
    parameter int CLEAR_CYCLES = 2,
    localparam int IDX_W = $clog2(NUM_LANES),
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] lane_req,
    output logic [NUM_LANES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [CNT_W-1:0]     dwell_cnt,
    output logic                 switch_pulse,
    output logic                 all_red
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    if (NUM_LANES < 2 || NUM_LANES > 16 || DWELL_CYCLES < 1 || DWELL_CYCLES > 255 ||
        CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15) begin : g_param_range
        $error("lane_rr_scheduler: parameter out of range");
    end

    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     dwell_q, dwell_d;
    logic                 pulse_q, pulse_d;

    logic                 cand_found_s;
    logic [IDX_W-1:0]     cand_idx_s;
    logic                 green_switch_s;
    logic [CNT_W-1:0]     green_dwell_s;

    function automatic logic [NUM_LANES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_LANES-1:0] v;
        v = {NUM_LANES{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Descending scan so the nearest lane after the current one wins.
    function automatic logic [IDX_W:0] find_next(input logic [NUM_LANES-1:0] req,
                                                 input logic [IDX_W-1:0]     cur);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               pos;
        found = 1'b0;
        idx   = cur;
        for (int k = NUM_LANES - 1; k >= 1; k--) begin
            pos = int'(cur) + k;
            if (pos >= NUM_LANES) begin
                pos = pos - NUM_LANES;
            end else begin
                pos = pos;
            end
            if (req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Candidate search excluding the current lane.
    always_comb begin
        {cand_found_s, cand_idx_s} = find_next(lane_req, idx_q);
    end

    // GREEN-state decision: switch, or hold with the next dwell value.
    always_comb begin
        green_switch_s = 1'b0;
        green_dwell_s  = {CNT_W{1'b0}};
        if (dwell_q == DWELL_LAST) begin
            if (cand_found_s) begin
                green_switch_s = 1'b1;
            end else begin
                green_dwell_s = {CNT_W{1'b0}};
            end
        end else if (lane_req[idx_q]) begin
            green_dwell_s = dwell_q + CNT_W'(1);
        end else if (cand_found_s) begin
            green_switch_s = 1'b1;
        end else begin
            green_dwell_s = {CNT_W{1'b0}};
        end
    end

`ifdef ALL_RED_GAP_EN
    typedef enum logic {
        ST_GREEN = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [3:0] CLR_LAST = 4'(CLEAR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] clr_q, clr_d;
    logic       all_red_q, all_red_d;

    // Next-state and output logic; lane_req is ignored while clearing.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        all_red_d = all_red_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        dwell_d   = dwell_q;
        pulse_d   = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (green_switch_s) begin
                    state_d   = ST_CLEAR;
                    clr_d     = 4'd0;
                    all_red_d = 1'b1;
                    grant_d   = {NUM_LANES{1'b0}};
                    idx_d     = cand_idx_s;
                    dwell_d   = {CNT_W{1'b0}};
                    pulse_d   = 1'b1;
                end else begin
                    dwell_d = green_dwell_s;
                end
            end
            ST_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d   = ST_GREEN;
                    clr_d     = 4'd0;
                    all_red_d = 1'b0;
                    grant_d   = onehot(idx_q);
                    dwell_d   = {CNT_W{1'b0}};
                end else begin
                    clr_d = clr_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_GREEN;
                clr_d     = 4'd0;
                all_red_d = 1'b0;
                grant_d   = onehot(idx_q);
                dwell_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_GREEN;
            clr_q     <= 4'd0;
            all_red_q <= 1'b0;
            grant_q   <= {{(NUM_LANES-1){1'b0}}, 1'b1};
            idx_q     <= {IDX_W{1'b0}};
            dwell_q   <= {CNT_W{1'b0}};
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            all_red_q <= all_red_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            pulse_q   <= pulse_d;
        end
    end

    assign all_red = all_red_q;
`else
    // Direct GREEN-to-GREEN handover.
    always_comb begin
        grant_d = grant_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        pulse_d = 1'b0;
        if (green_switch_s) begin
            grant_d = onehot(cand_idx_s);
            idx_d   = cand_idx_s;
            dwell_d = {CNT_W{1'b0}};
            pulse_d = 1'b1;
        end else begin
            dwell_d = green_dwell_s;
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= {{(NUM_LANES-1){1'b0}}, 1'b1};
            idx_q   <= {IDX_W{1'b0}};
            dwell_q <= {CNT_W{1'b0}};
            pulse_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            pulse_q <= pulse_d;
        end
    end

    assign all_red = 1'b0;
`endif

    assign grant        = grant_q;
    assign grant_idx    = idx_q;
    assign dwell_cnt    = dwell_q;
    assign switch_pulse = pulse_q;

endmodule
